// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-word ALU sequencer:
//   - ALU opcodes understood by the shared 8-bit ALU instance
//   - command operation encodings (cmd_op)
//   - sequencer state encoding
//   - helper mapping (command op, first word) -> ALU opcode
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0100;  // A + B
  localparam logic [3:0] ALU_ADC   = 4'b0101;  // A + B + ci
  localparam logic [3:0] ALU_SUBAB = 4'b0010;  // A - B
  localparam logic [3:0] ALU_SUBBA = 4'b0011;  // B - A
  localparam logic [3:0] ALU_SBCAB = 4'b0110;  // A - B with carry (ARM style)
  localparam logic [3:0] ALU_SBCBA = 4'b0111;  // B - A with carry (ARM style)
  localparam logic [3:0] ALU_NOP   = 4'b0000;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_RSB = 2'b10,
    OP_RSV = 2'b11   // reserved, behaves as ADD
  } cmd_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Word 0 uses the plain opcode; later words use the carry-in variant so
  // the carry (or ARM-style not-borrow) chains across words.
  function automatic logic [3:0] alu_opcode(input cmd_op_t op, input logic first);
    case (op)
      OP_SUB:  return first ? ALU_SUBAB : ALU_SBCAB;
      OP_RSB:  return first ? ALU_SUBBA : ALU_SBCBA;
      default: return first ? ALU_ADD   : ALU_ADC;
    endcase
  endfunction

endpackage

// File: rtl/alu_multiword_seq_if.sv
// ---------------------------------------------------------------------------
// alu_multiword_seq_if
// Handshake bundle between the instruction decoder (master) and the
// multi-word ALU sequencer (slave).
//   cmd_*   : command channel (op, word count minus 1)
//   in_*    : operand word pairs, LS word first
//   out_*   : result words, LS word first, out_last on the MS word
//   flags_* : one-cycle final NZCV report per command
// ---------------------------------------------------------------------------
interface alu_multiword_seq_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  logic             flags_valid;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output cmd_valid, cmd_op, cmd_len,
    input  cmd_ready,
    output in_valid, in_a, in_b,
    input  in_ready,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  flags_valid, flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len,
    output cmd_ready,
    input  in_valid, in_a, in_b,
    output in_ready,
    output out_valid, out_data, out_last,
    input  out_ready,
    output flags_valid, flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/alu_multiword_seq.sv
// ---------------------------------------------------------------------------
// alu_multiword_seq
// Sequences a shared WIDTH-bit ALU to perform multi-word ADD / SUB / RSB,
// chaining the carry from word to word.
// Ports:
//   clk, reset        : clock (rising edge), async active-high reset
//   bus (slave)       : cmd / operand / result / flags handshakes
//   busy              : high whenever the sequencer is not idle
//   alu_control/ci/a/b: drive the external ALU (only non-zero in EXEC)
//   alu_out/co/ovf/n/z: ALU result and status, captured in EXEC
// ---------------------------------------------------------------------------
module alu_multiword_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4,
  parameter int LEN_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  alu_multiword_seq_if.slave bus,
  output logic             busy,
  output logic [3:0]       alu_control,
  output logic             alu_ci,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_co,
  input  logic             alu_ovf,
  input  logic             alu_n,
  input  logic             alu_z
);

  state_t           state, state_nx;
  cmd_op_t          op_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [WIDTH-1:0] opa_q, opb_q, data_q;
  logic             carry_q, z_acc_q, n_sh_q, v_sh_q;
  logic             fn_q, fz_q, fc_q, fv_q;

  logic cmd_fire, in_fire, out_fire, is_last, first_word;

  assign cmd_fire   = bus.cmd_valid & (state == S_IDLE);
  assign in_fire    = bus.in_valid  & (state == S_FETCH);
  assign out_fire   = bus.out_ready & (state == S_EMIT);
  assign is_last    = (cnt_q == len_q);
  assign first_word = (cnt_q == '0);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  // NOTE: a default assignment first keeps every path assigned, so no latch
  // is inferred when a case arm does not change the state.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cmd_fire) state_nx = S_FETCH;
      S_FETCH: if (in_fire)  state_nx = S_EXEC;
      S_EXEC:                state_nx = S_EMIT;
      S_EMIT:  if (out_fire) state_nx = is_last ? S_DONE : S_FETCH;
      S_DONE:                state_nx = S_IDLE;
      default:               state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registers only; no input reaches an
  // output combinationally.
  always_comb begin
    bus.cmd_ready   = 1'b0;
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_last    = 1'b0;
    bus.flags_valid = 1'b0;
    alu_control     = ALU_NOP;
    alu_ci          = 1'b0;
    alu_a           = '0;
    alu_b           = '0;
    case (state)
      S_IDLE:  bus.cmd_ready = 1'b1;
      S_FETCH: bus.in_ready  = 1'b1;
      S_EXEC: begin
        alu_control = alu_opcode(op_q, first_word);
        alu_ci      = first_word ? 1'b0 : carry_q;
        alu_a       = opa_q;
        alu_b       = opb_q;
      end
      S_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = is_last;
      end
      S_DONE:  bus.flags_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy         = (state != S_IDLE);
  assign bus.out_data = data_q;
  assign bus.flag_n   = fn_q;
  assign bus.flag_z   = fz_q;
  assign bus.flag_c   = fc_q;
  assign bus.flag_v   = fv_q;

  // Datapath registers. Everything is small control state, so all of it is
  // reset; an aborted command leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_ADD;
      len_q   <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      z_acc_q <= 1'b0;
      n_sh_q  <= 1'b0;
      v_sh_q  <= 1'b0;
      fn_q    <= 1'b0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_fire) begin
          op_q    <= cmd_op_t'(bus.cmd_op);
          // Over-long commands are clamped to the maximum word count.
          len_q   <= (32'(bus.cmd_len) >= WORDS) ? LEN_W'(WORDS - 1) : bus.cmd_len;
          cnt_q   <= '0;
          z_acc_q <= 1'b1;
        end
        S_FETCH: if (in_fire) begin
          opa_q <= bus.in_a;
          opb_q <= bus.in_b;
        end
        S_EXEC: begin
          data_q  <= alu_out;
          carry_q <= alu_co;
          z_acc_q <= z_acc_q & alu_z;
          n_sh_q  <= alu_n;
          v_sh_q  <= alu_ovf;
        end
        S_EMIT: if (out_fire) begin
          if (is_last) begin
            // The last word's shadows become the reported flags.
            fn_q <= n_sh_q;
            fz_q <= z_acc_q;
            fc_q <= carry_q;
            fv_q <= v_sh_q;
          end else begin
            cnt_q <= cnt_q + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiword_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_multiword_seq
// Drives multi-word commands into alu_multiword_seq with a behavioural model
// of the external 8-bit ALU. Expected result words and final flags come from
// full-width arithmetic on the whole operand, queued when the command is
// issued and popped as the DUT produces results.
// ---------------------------------------------------------------------------
module tb_alu_multiword_seq;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int LEN_W = 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic             clk;
  logic             reset;
  logic             busy;
  logic [3:0]       alu_control;
  logic             alu_ci;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic             alu_co, alu_ovf, alu_n, alu_z;

  alu_multiword_seq_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  alu_multiword_seq #(.WIDTH(WIDTH), .WORDS(WORDS), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .alu_control (alu_control),
    .alu_ci      (alu_ci),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_out     (alu_out),
    .alu_co      (alu_co),
    .alu_ovf     (alu_ovf),
    .alu_n       (alu_n),
    .alu_z       (alu_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: subtraction is x + ~y + cin, ARM-style carry.
  always_comb begin
    logic [WIDTH-1:0] x, y;
    logic             cin;
    logic [WIDTH:0]   s;
    x = '0; y = '0; cin = 1'b0;
    case (alu_control)
      4'b0100: begin x = alu_a; y = alu_b;  cin = 1'b0;   end
      4'b0101: begin x = alu_a; y = alu_b;  cin = alu_ci; end
      4'b0010: begin x = alu_a; y = ~alu_b; cin = 1'b1;   end
      4'b0110: begin x = alu_a; y = ~alu_b; cin = alu_ci; end
      4'b0011: begin x = alu_b; y = ~alu_a; cin = 1'b1;   end
      4'b0111: begin x = alu_b; y = ~alu_a; cin = alu_ci; end
      default: ;
    endcase
    s       = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin);
    alu_out = s[WIDTH-1:0];
    alu_co  = s[WIDTH];
    alu_n   = s[WIDTH-1];
    alu_z   = (s[WIDTH-1:0] == '0);
    alu_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  end

  int total = 0;
  int bad   = 0;

  beat_t      sb_q[$];
  logic [3:0] fl_q[$];   // {n, z, c, v}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_opc(input logic [1:0] op, input int i);
    case (op)
      2'b01:   return (i == 0) ? 4'b0010 : 4'b0110;
      2'b10:   return (i == 0) ? 4'b0011 : 4'b0111;
      default: return (i == 0) ? 4'b0100 : 4'b0101;
    endcase
  endfunction

  // Full-width reference; also gives the carry into each word for alu_ci.
  task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] a,
                         input logic [31:0] b, input int stall_in, input int stall_out);
    logic [31:0] mask, x, y, res, mi;
    logic [32:0] r, ri;
    logic        c0;
    int          nb;
    beat_t       bt;
    logic [3:0]  fl;

    nb   = (len + 1) * WIDTH;
    mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'h1 << nb) - 32'h1);
    case (op)
      2'b01:   begin x = a & mask; y = ~b & mask; c0 = 1'b1; end
      2'b10:   begin x = b & mask; y = ~a & mask; c0 = 1'b1; end
      default: begin x = a & mask; y = b & mask;  c0 = 1'b0; end
    endcase
    r   = {1'b0, x} + {1'b0, y} + 33'(c0);
    res = r[31:0] & mask;
    for (int i = 0; i <= len; i++) begin
      bt.data = res[i*WIDTH +: WIDTH];
      bt.last = (i == len);
      sb_q.push_back(bt);
    end
    fl_q.push_back({res[nb-1], (res == 32'h0), r[nb],
                    (x[nb-1] == y[nb-1]) && (res[nb-1] != x[nb-1])});

    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LEN_W'(len);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("busy_after_cmd", busy, 1);

    for (int i = 0; i <= len; i++) begin
      for (int s = 0; s < stall_in; s++) begin
        check("fetch_hold_in_ready", bus.in_ready, 1);
        @(negedge clk);
      end
      check("in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_a     = a[i*WIDTH +: WIDTH];
      bus.in_b     = b[i*WIDTH +: WIDTH];
      @(negedge clk);
      bus.in_valid = 1'b0;
      // EXEC
      mi = (32'h1 << (i * WIDTH)) - 32'h1;
      ri = {1'b0, x & mi} + {1'b0, y & mi} + 33'(c0);
      check("alu_control", alu_control, exp_opc(op, i));
      check("alu_ci", alu_ci, (i == 0) ? 1'b0 : ri[i*WIDTH]);
      check("alu_a", alu_a, a[i*WIDTH +: WIDTH]);
      check("alu_b", alu_b, b[i*WIDTH +: WIDTH]);
      @(negedge clk);
      // EMIT
      for (int s = 0; s < stall_out; s++) begin
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_out_data", bus.out_data, sb_q[0].data);
        check("stall_out_last", bus.out_last, sb_q[0].last);
        @(negedge clk);
      end
      bt = sb_q.pop_front();
      check("out_valid", bus.out_valid, 1);
      check("out_data", bus.out_data, bt.data);
      check("out_last", bus.out_last, bt.last);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("one_beat_only", bus.out_valid, 0);
    end

    // DONE
    fl = fl_q.pop_front();
    check("flags_valid", bus.flags_valid, 1);
    check("flags_nzcv", {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, fl);
    @(negedge clk);
    check("flags_pulse_end", bus.flags_valid, 0);
    check("back_to_idle", bus.cmd_ready, 1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_flags_valid", bus.flags_valid, 0);
    check("rst_flags", {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}, 0);
    check("rst_alu_control", alu_control, 0);

    // Directed cases
    run_cmd(2'b00, 1, 32'h01FF, 32'h0001, 0, 0);
    run_cmd(2'b01, 1, 32'h0100, 32'h0001, 0, 0);
    run_cmd(2'b10, 0, 32'h05,   32'h05,   0, 0);
    run_cmd(2'b00, 1, 32'h7FFF, 32'h0001, 0, 0);
    // Backpressure on both sides
    run_cmd(2'b01, 1, 32'h1234, 32'h5678, 3, 4);
    // Full-length and reserved-op commands
    run_cmd(2'b11, 3, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
    run_cmd(2'b10, 3, 32'h8000_0000, 32'h0000_0001, 0, 1);

    for (int k = 0; k < 6; k++)
      run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom, $urandom, 0, 0);

    // Reset in EXEC of word 1 of a 4-word ADD
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_len   = 2'd3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'hFF;
    bus.in_b      = 8'h01;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'h10;
    bus.in_b      = 8'h20;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    check("abort_word1_opc", alu_control, 4'b0101);
    check("abort_word1_ci", alu_ci, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_alu_control", alu_control, 0);
    check("abort_alu_ab", {alu_a, alu_b}, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_data", bus.out_data, 0);
    check("abort_cmd_ready", bus.cmd_ready, 1);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      check("abort_no_flags_rst", bus.flags_valid, 0);
    end
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("abort_no_flags", bus.flags_valid, 0);
    end
    run_cmd(2'b00, 0, 32'h01, 32'h01, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard against a lockup anywhere in the run.
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", total, 0);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_multiword_seq.md
Name: alu_multiword_seq

Overview:
- Controller that sequences the shared 8-bit ALU to perform multi-word (multi-precision) ADD / SUB operations.
- Chains the carry across words:
  - word 0 uses the plain ALU opcode;
  - words 1..n use the carry-in variant, fed with the previous word's CO.
- Operands stream in LS-word first over a valid/ready port. Results stream out the same way.
- Final NZCV flags are reported once per command. Sits between the instruction decoder and the ALU instance.

Parameters:
- WIDTH, 8: ALU word width; must match the ALU instance.
- WORDS, 4: maximum words per command (≥1).
- LEN_W, 2: width of cmd_len; equals clog2(WORDS), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 ADD (A+B), 01 SUB (A-B), 10 RSB (B-A), 11 reserved (treated as ADD).
- cmd_len  in  LEN_W  word count minus 1; values ≥WORDS clamp to WORDS-1.
- in_valid  in  1  operand word pair valid.
- in_ready  out  1  high only in FETCH.
- in_a, in_b  in  WIDTH each  operand words, LS word first.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  result word.
- out_last  out  1  marks the final (MS) result word.
- flags_valid  out  1  one-cycle pulse carrying the final flags.
- flag_n, flag_z, flag_c, flag_v  out  1 each  final flags.
- busy  out  1  high whenever state ≠ IDLE.
- alu_control  out  4  ALU opcode.
- alu_ci  out  1  ALU carry in.
- alu_a, alu_b  out  WIDTH each  ALU operands.
- alu_out  in  WIDTH  ALU result.
- alu_co, alu_ovf, alu_n, alu_z  in  1 each  ALU status outputs.

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0, except cmd_ready=1 once in IDLE. Carry, z_acc and the word counter are cleared. Any in-flight command is abandoned with no flags pulse.
- State IDLE: on cmd_valid&cmd_ready, latch op and len, set word counter=0 and z_acc=1, then go to FETCH.
- State FETCH: on in_valid&in_ready, register in_a/in_b into opa/opb, then go to EXEC.
- State EXEC (exactly one cycle): ALU inputs are driven from the registers. At the clock edge:
  - capture alu_out into out_data;
  - capture alu_co into the carry register;
  - z_acc &= alu_z;
  - capture alu_n and alu_ovf into shadow flag registers.
  - Then go to EMIT.
- State EMIT: out_valid=1; out_last=1 when counter==len. On out_valid&out_ready:
  - if not last: counter++, go to FETCH;
  - if last: go to DONE.
- State DONE (one cycle): flags_valid=1 and the flags are driven. Then return to IDLE. The flag registers hold their values until the next DONE.
- ALU opcode selection during EXEC:
  - ADD: word 0 uses 0100 with alu_ci=0; later words use 0101 with alu_ci=carry.
  - SUB: word 0 uses 0010 with alu_ci=0 (ignored by the ALU); later words use 0110 with alu_ci=carry.
  - RSB: word 0 uses 0011 with alu_ci=0 (ignored); later words use 0111 with alu_ci=carry.
  - Outside EXEC: alu_control=0000 and alu_a=alu_b=0.
- Carry convention: ARM style. For subtraction, C=1 means no borrow. The carry chains unmodified between words.
- Final flags:
  - N = MS-word alu_n;
  - V = MS-word alu_ovf;
  - C = MS-word alu_co;
  - Z = AND of alu_z over all words.
- Latency: a 1-word command with no stalls takes 5 cycles from cmd accept to flags_valid. Each extra word adds 3 cycles.
- Backpressure:
  - out_ready low holds EMIT with out_data and out_last stable;
  - in_valid low holds FETCH.
- cmd_valid is ignored while busy. Inputs are never combinationally passed to outputs.

Decomposition:
- Shared package (alu_pkg) holds:
  - the ALU opcode localparams: ADD 0100, ADC 0101, SUBAB 0010, SUBBA 0011, SBCAB 0110, SBCBA 0111;
  - the cmd_op encodings;
  - the state encoding.
- No sub-module is needed. The ALU is instantiated by the parent, not inside this block.

Test Plan:
- ADD, len=1 (2 words), A=0x01FF, B=0x0001: out words 0x00 then 0x02 with out_last on the second; flags N=0, Z=0, C=0, V=0.
- SUB, len=1, A=0x0100, B=0x0001: out 0xFF, 0x00; flags Z=0, C=1, N=0, V=0.
- RSB, len=0, A=0x05, B=0x05: out 0x00; flags Z=1, C=1. Check alu_control==0011 during EXEC.
- ADD, len=1, A=0x7FFF, B=0x0001: out 0x00, 0x80; flags N=1, V=1, C=0, Z=0. Check word 1 uses alu_control==0101 with alu_ci=1.
- Backpressure: hold out_ready=0 for 4 cycles in EMIT. out_data stays stable and exactly one beat is consumed. Also hold in_valid=0 in FETCH; state stays FETCH.
- Reset mid-command:
  - assert reset in EXEC of word 1 of a 4-word ADD;
  - outputs clear immediately (async) and no flags_valid pulse occurs;
  - the next command, ADD len=0 A=0x01 B=0x01, yields 0x02 with alu_ci=0 (carry cleared).
